// File: rtl/fetch_pkg.sv
// Shared widths and state encoding for the instruction fetch sequencer.
package fetch_pkg;
  localparam int WORD    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: load-enabled, async active-low reset to the reset vector.
module pc_reg #(
  parameter int              WORD         = 64,
  parameter logic [WORD-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [WORD-1:0] pc_d,
  output logic [WORD-1:0] pc_q
);
  import fetch_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc_q <= RESET_VECTOR;
    else if (load_i) pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC, handshakes with instruction memory,
// takes aligned redirects and locks up in FAULT on a misaligned one.
//
// state | meaning
// IDLE  | one cycle after reset, no request issued
// FETCH | requesting at PC, capturing returned words
// FAULT | misaligned redirect seen, frozen until reset
module fetch_sequencer #(
  parameter int                       WORD         = fetch_pkg::WORD,
  parameter logic [WORD-1:0]          RESET_VECTOR = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [WORD-1:0]             branch_target,
  output logic                        imem_req,
  output logic [WORD-1:0]             imem_addr,
  input  logic                        imem_ready,
  input  logic [fetch_pkg::INSTR_W-1:0] imem_rdata,
  output logic                        instr_valid,
  output logic [fetch_pkg::INSTR_W-1:0] instr,
  output logic [WORD-1:0]             instr_pc,
  output logic                        fault,
  output logic [31:0]                 fetch_count
);
  import fetch_pkg::*;

  fetch_state_t         state_q, state_d;
  logic [WORD-1:0]      pc_q, pc_d;
  logic                 pc_load;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [WORD-1:0]      ipc_q, ipc_d;
  logic                 fault_q, fault_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 redir_ok, redir_bad, handshake;

  pc_reg #(.WORD(WORD), .RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (pc_load),
    .pc_d   (pc_d),
    .pc_q   (pc_q)
  );

  assign redir_ok  = branch_taken && (branch_target[1:0] == 2'b00);
  assign redir_bad = branch_taken && (branch_target[1:0] != 2'b00);
  assign imem_req  = (state_q == FETCH) && !(valid_q && stall);
  assign handshake = imem_req && imem_ready;

  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      IDLE, FETCH: begin
        if (state_q == IDLE) state_d = FETCH;
        // Redirects take priority over both stall and a coincident handshake.
        if (redir_bad) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (redir_ok) begin
          pc_load = 1'b1;
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (handshake) begin
          pc_load = 1'b1;
          pc_d    = pc_q + WORD'(PC_INC);
          valid_d = 1'b1;
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          cnt_d   = cnt_q + 32'd1;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus hand-written fault/reset/wrap sequences.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int total = 0;
  int passed = 0;

  fetch_sequencer #(.WORD(64), .RESET_VECTOR(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_ipc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
    logic        e_fault;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic st, logic br, logic [63:0] tgt, logic rdy, logic [31:0] rd,
                              logic req, logic [63:0] addr, logic vld, logic [63:0] ipc,
                              logic [31:0] ins, logic [31:0] cnt, logic flt);
    vec_t v;
    v.stall = st; v.br = br; v.tgt = tgt; v.ready = rdy; v.rdata = rd;
    v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_ipc = ipc;
    v.e_instr = ins; v.e_cnt = cnt; v.e_fault = flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_req"}, 64'(imem_req), 64'd0);
    chk({tag, " imem_addr"}, imem_addr, 64'h0);
    chk({tag, " instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, " instr"}, 64'(instr), 64'd0);
    chk({tag, " instr_pc"}, instr_pc, 64'h0);
    chk({tag, " fault"}, 64'(fault), 64'd0);
    chk({tag, " fetch_count"}, 64'(fetch_count), 64'd0);
  endtask

  task automatic drive(input logic st, input logic br, input logic [63:0] tgt,
                       input logic rdy, input logic [31:0] rd);
    stall = st; branch_taken = br; branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
  endtask

  initial begin
    //            st br tgt        rdy rdata       req addr       vld ipc       instr       cnt flt
    vecs[0]  = mk(0, 0, 64'h0,     1, 32'h0,       0, 64'h0,     0, 64'h0,   32'h0,      0, 0);
    vecs[1]  = mk(0, 0, 64'h0,     1, 32'h11,      1, 64'h0,     0, 64'h0,   32'h0,      0, 0);
    vecs[2]  = mk(0, 0, 64'h0,     1, 32'h22,      1, 64'h4,     1, 64'h0,   32'h11,     1, 0);
    vecs[3]  = mk(0, 0, 64'h0,     1, 32'h33,      1, 64'h8,     1, 64'h4,   32'h22,     2, 0);
    vecs[4]  = mk(1, 0, 64'h0,     1, 32'hdead,    0, 64'hC,     1, 64'h8,   32'h33,     3, 0);
    vecs[5]  = mk(1, 0, 64'h0,     1, 32'hdead,    0, 64'hC,     1, 64'h8,   32'h33,     3, 0);
    vecs[6]  = mk(1, 0, 64'h0,     1, 32'hdead,    0, 64'hC,     1, 64'h8,   32'h33,     3, 0);
    vecs[7]  = mk(0, 0, 64'h0,     1, 32'h44,      1, 64'hC,     1, 64'h8,   32'h33,     3, 0);
    vecs[8]  = mk(0, 1, 64'h100,   1, 32'h55,      1, 64'h10,    1, 64'hC,   32'h44,     4, 0);
    vecs[9]  = mk(0, 0, 64'h0,     1, 32'h66,      1, 64'h100,   0, 64'h0,   32'h0,      4, 0);
    vecs[10] = mk(0, 1, 64'h1C,    0, 32'hbad,     1, 64'h104,   1, 64'h100, 32'h66,     5, 0);
    vecs[11] = mk(0, 0, 64'h0,     1, 32'h77,      1, 64'h1C,    0, 64'h0,   32'h0,      5, 0);
    vecs[12] = mk(0, 0, 64'h0,     0, 32'hbad,     1, 64'h20,    1, 64'h1C,  32'h77,     6, 0);
    vecs[13] = mk(0, 0, 64'h0,     0, 32'hbad,     1, 64'h20,    0, 64'h0,   32'h0,      6, 0);
    vecs[14] = mk(0, 0, 64'h0,     0, 32'hbad,     1, 64'h20,    0, 64'h0,   32'h0,      6, 0);
    vecs[15] = mk(0, 0, 64'h0,     0, 32'hbad,     1, 64'h20,    0, 64'h0,   32'h0,      6, 0);
    vecs[16] = mk(0, 0, 64'h0,     1, 32'h88,      1, 64'h20,    0, 64'h0,   32'h0,      6, 0);
    vecs[17] = mk(0, 0, 64'h0,     0, 32'hbad,     1, 64'h24,    1, 64'h20,  32'h88,     7, 0);
    vecs[18] = mk(0, 1, 64'h102,   1, 32'hbad,     1, 64'h24,    0, 64'h0,   32'h0,      7, 0);

    #1 chk_reset_vals("por");
    @(posedge clk); #2 reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ready, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d imem_req", i), 64'(imem_req), 64'(vecs[i].e_req));
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
        chk($sformatf("v%0d instr", i), 64'(instr), 64'(vecs[i].e_instr));
      end
      chk($sformatf("v%0d fetch_count", i), 64'(fetch_count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d fault", i), 64'(fault), 64'(vecs[i].e_fault));
    end

    // FAULT must ignore all inputs, including aligned redirects and ready data.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'b1, $urandom);
      #1;
      chk($sformatf("fault%0d imem_req", i), 64'(imem_req), 64'd0);
      chk($sformatf("fault%0d fault", i), 64'(fault), 64'd1);
      chk($sformatf("fault%0d instr_valid", i), 64'(instr_valid), 64'd0);
      chk($sformatf("fault%0d imem_addr", i), imem_addr, 64'h24);
      chk($sformatf("fault%0d fetch_count", i), 64'(fetch_count), 64'd7);
    end

    // Reset asserted between edges clears everything without a clock.
    @(negedge clk); #2 reset = 1'b0;
    #1 chk_reset_vals("rst_from_fault");
    @(posedge clk); #2 reset = 1'b1;

    @(negedge clk); drive(0, 0, 64'h0, 1, 32'h99); #1;
    chk("restart idle req", 64'(imem_req), 64'd0);
    @(negedge clk); #1;
    chk("restart fetch req", 64'(imem_req), 64'd1);
    chk("restart fetch addr", imem_addr, 64'h0);
    @(negedge clk); imem_rdata = 32'hAB; #1;
    chk("restart valid", 64'(instr_valid), 64'd1);
    chk("restart instr", 64'(instr), 64'h99);
    chk("restart cnt", 64'(fetch_count), 64'd1);
    chk("restart addr", imem_addr, 64'h4);

    // Mid-fetch reset: handshake pending at 0x4 must not be captured.
    #3 reset = 1'b0;
    #1 chk_reset_vals("rst_mid_fetch");
    @(posedge clk); #1 chk_reset_vals("rst_held_edge");
    #1 reset = 1'b1;

    @(negedge clk); drive(0, 0, 64'h0, 1, 32'h1); #1;
    chk("rs2 idle req", 64'(imem_req), 64'd0);
    @(negedge clk); #1;
    chk("rs2 addr", imem_addr, 64'h0);

    // PC wraps modulo 2^64 after the top word.
    @(negedge clk); drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h2); #1;
    chk("wrap pre cnt", 64'(fetch_count), 64'd1);
    @(negedge clk); drive(0, 0, 64'h0, 1, 32'hC0DE); #1;
    chk("wrap top addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap top valid", 64'(instr_valid), 64'd0);
    @(negedge clk); imem_ready = 1'b0; #1;
    chk("wrap addr", imem_addr, 64'h0);
    chk("wrap ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap instr", 64'(instr), 64'hC0DE);
    chk("wrap cnt", 64'(fetch_count), 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
